// File: rtl/sync_fifo_8x32.sv
// rtl/sync_fifo_8x32.sv - 8x32 single-clock FIFO with registered per-request ack/err flags
// Optional almost_full/almost_empty outputs are enabled with FIFO_ALMOST_FLAGS_EN.
module sync_fifo_8x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  full,
  output logic                  empty,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic                  almost_full,
  output logic                  almost_empty,
`endif
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam logic [ADDR_WIDTH:0]   COUNT_MAX = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    OP_NOP,
    OP_WRITE,
    OP_WR_ERR,
    OP_READ,
    OP_RD_ERR
  } op_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  op_t                   op;

  assign full  = (data_count == COUNT_MAX);
  assign empty = (data_count == '0);

`ifdef FIFO_ALMOST_FLAGS_EN
  assign almost_full  = (data_count >= (COUNT_MAX - COUNT_ONE));
  assign almost_empty = (data_count <= COUNT_ONE);
`endif

  // Concurrent wr_en and rd_en is deliberately a no-op, not a pass-through.
  always_comb begin
    op = OP_NOP;
    if (wr_en && !rd_en) begin
      op = full ? OP_WR_ERR : OP_WRITE;
    end else if (rd_en && !wr_en) begin
      op = empty ? OP_RD_ERR : OP_READ;
    end
  end

  always_ff @(posedge clk) begin
    if (op == OP_WRITE) begin
      mem[tail] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      dout       <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      wr_ack <= (op == OP_WRITE);
      wr_err <= (op == OP_WR_ERR);
      rd_ack <= (op == OP_READ);
      rd_err <= (op == OP_RD_ERR);
      case (op)
        OP_WRITE: begin
          tail       <= tail + PTR_ONE;
          data_count <= data_count + COUNT_ONE;
        end
        OP_READ: begin
          dout       <= mem[head];
          head       <= head + PTR_ONE;
          data_count <= data_count - COUNT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_8x32.sv
// tb/tb_sync_fifo_8x32.sv - directed scoreboard bench for sync_fifo_8x32
module tb_sync_fifo_8x32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] din;
  logic [31:0] dout;
  logic [3:0]  data_count;
  logic        full;
  logic        empty;
  logic        wr_ack;
  logic        wr_err;
  logic        rd_ack;
  logic        rd_err;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic        almost_full;
  logic        almost_empty;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] sb_q[$];
  int          m_count = 0;
  logic [31:0] m_dout = '0;

  sync_fifo_8x32 dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .din        (din),
    .dout       (dout),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
`ifdef FIFO_ALMOST_FLAGS_EN
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`endif
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_wa, input logic e_we,
                           input logic e_ra, input logic e_re);
    check({tag, ".wr_ack"}, 32'(wr_ack), 32'(e_wa));
    check({tag, ".wr_err"}, 32'(wr_err), 32'(e_we));
    check({tag, ".rd_ack"}, 32'(rd_ack), 32'(e_ra));
    check({tag, ".rd_err"}, 32'(rd_err), 32'(e_re));
    check({tag, ".count"}, 32'(data_count), 32'(m_count));
    check({tag, ".full"}, 32'(full), 32'(m_count == 8));
    check({tag, ".empty"}, 32'(empty), 32'(m_count == 0));
    check({tag, ".dout"}, dout, m_dout);
`ifdef FIFO_ALMOST_FLAGS_EN
    check({tag, ".almost_full"}, 32'(almost_full), 32'(m_count >= 7));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(m_count <= 1));
`endif
  endtask

  // One request cycle: drive, clock, update the model from its pre-edge state, compare.
  task automatic step(input string tag, input logic w, input logic r, input logic [31:0] d);
    logic e_wa, e_we, e_ra, e_re;
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    e_wa = w && !r && (m_count < 8);
    e_we = w && !r && (m_count == 8);
    e_ra = r && !w && (m_count > 0);
    e_re = r && !w && (m_count == 0);
    if (e_wa) begin
      sb_q.push_back(d);
      m_count++;
    end
    if (e_ra) begin
      m_dout = sb_q.pop_front();
      m_count--;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_all(tag, e_wa, e_we, e_ra, e_re);
  endtask

  initial begin
    logic [31:0] wr_data [8];
    logic [31:0] err_data [4];
    wr_data  = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
    err_data = '{32'h99, 32'hAA, 32'hBB, 32'h345};

    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    step("rd_empty", 1'b0, 1'b1, '0);

    for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0, wr_data[i]);
    for (int i = 0; i < 4; i++) step("wr_full", 1'b1, 1'b0, err_data[i]);

    step("rd_a", 1'b0, 1'b1, '0);
    step("rd_b", 1'b0, 1'b1, '0);
    step("wrap_a", 1'b1, 1'b0, 32'h345);
    step("wrap_b", 1'b1, 1'b0, 32'hCC);

    for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, '0);
    step("rd_under", 1'b0, 1'b1, '0);

    for (int i = 0; i < 3; i++) step("refill", 1'b1, 1'b0, 32'hD0 + 32'(i));
    step("both", 1'b1, 1'b1, 32'hEE);
    step("both2", 1'b1, 1'b1, 32'hEF);
    step("rd_after_both", 1'b0, 1'b1, '0);
    step("wr_more", 1'b1, 1'b0, 32'hF0);

    // Reset mid-period: outputs must clear before the next rising edge.
    #2;
    reset_n = 1'b0;
    #1;
    sb_q.delete();
    m_count = 0;
    m_dout  = '0;
    check_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("post_rst_rd", 1'b0, 1'b1, '0);
    step("post_rst_wr", 1'b1, 1'b0, 32'h1234);
    step("post_rst_rd2", 1'b0, 1'b1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
